// File: rtl/zion_arb_pkg.sv
// Shared types and the rotated-priority pick function for the round-robin lock arbiter.
package zion_arb_pkg;

  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxPtrW = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Searches from ptr+1 upward with wrap over the first n requesters; returns one-hot.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0]  req,
                                                input logic [MaxPtrW-1:0] ptr,
                                                input int unsigned        n);
    logic [MaxReq-1:0]  gnt;
    logic [MaxPtrW-1:0] idx;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = MaxPtrW'((32'(ptr) + k) % n);
      if (k <= n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/zion_arb_rr_lock_if.sv
// Requester-side and shared-port handshake bundle for zion_arb_rr_lock.
interface zion_arb_rr_lock_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        iVld;
  logic [NUM_REQ-1:0]        oRdy;
  logic [NUM_REQ*DATA_W-1:0] iDat;
  logic [NUM_REQ-1:0]        iLast;
  logic                      oVld;
  logic                      iRdy;
  logic [DATA_W-1:0]         oDat;
  logic                      oLast;
  logic [NUM_REQ-1:0]        oGnt;

  modport slave (
    input  iVld, iDat, iLast, iRdy,
    output oRdy, oVld, oDat, oLast, oGnt
  );

  modport master (
    output iVld, iDat, iLast, iRdy,
    input  oRdy, oVld, oDat, oLast, oGnt
  );
endinterface

// File: rtl/zion_arb_rr_pick.sv
// Combinational rotated-priority one-hot picker wrapping zion_arb_pkg::rr_pick.
module zion_arb_rr_pick
  import zion_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [MaxReq-1:0] req_ext;
  logic [MaxReq-1:0] gnt_ext;
  logic              unused_gnt;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    gnt_ext                = rr_pick(req_ext, MaxPtrW'(ptr_i), NUM_REQ);
  end

  assign gnt_o      = gnt_ext[NUM_REQ-1:0];
  assign unused_gnt = ^gnt_ext;

endmodule

// File: rtl/zion_arb_rr_lock.sv
// Round-robin N:1 arbiter with registered output stage; grant held per packet when
// ZION_ARB_RR_PKT_LOCK_EN is defined, otherwise re-arbitrated every beat.
module zion_arb_rr_lock
  import zion_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  zion_arb_rr_lock_if.slave bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > MaxReq) begin : g_bad_num_req
    $error("zion_arb_rr_lock: NUM_REQ must be within 2..32");
  end

  arb_state_e         state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic               last_q, last_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [NUM_REQ-1:0] rdy;
  logic [PtrW-1:0]    gnt_idx;
  logic [DATA_W-1:0]  sel_dat;
  logic               beat_last;
  logic               accept;

  zion_arb_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PtrW)
  ) u_pick (
    .req_i(bus.iVld),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt)
  );

  // Output register can take a beat whenever it is empty or being drained this cycle.
  assign rdy    = (state_q == LOCK) ? (gnt_q & {NUM_REQ{~vld_q | bus.iRdy}}) : '0;
  assign accept = |(bus.iVld & rdy);

  always_comb begin
    sel_dat = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        sel_dat = sel_dat | bus.iDat[i*DATA_W +: DATA_W];
        gnt_idx = gnt_idx | PtrW'(i);
      end
    end
  end

`ifdef ZION_ARB_RR_PKT_LOCK_EN
  assign beat_last = |(gnt_q & bus.iLast);
`else
  logic unused_last;
  assign unused_last = ^bus.iLast;
  assign beat_last   = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    last_d  = last_q;
    if (vld_q && bus.iRdy) vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.iVld) begin
          gnt_d   = pick_gnt;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          vld_d  = 1'b1;
          dat_d  = sel_dat;
          last_d = beat_last;
          if (beat_last) begin
            state_d = IDLE;
            ptr_d   = gnt_idx;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PtrW'(NUM_REQ - 1);
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
    end
  end

  assign bus.oRdy  = rdy;
  assign bus.oVld  = vld_q;
  assign bus.oDat  = dat_q;
  assign bus.oLast = last_q;
  assign bus.oGnt  = gnt_q;

endmodule

// File: tb/tb_zion_arb_rr_lock.sv
// Self-checking bench for zion_arb_rr_lock: vector table, directed corner sequences and
// randomized traffic against a behavioural owner/pointer model.
module tb_zion_arb_rr_lock;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
`ifdef ZION_ARB_RR_PKT_LOCK_EN
  localparam bit PktLock = 1'b1;
`else
  localparam bit PktLock = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zion_arb_rr_lock_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  zion_arb_rr_lock #(
    .NUM_REQ(N),
    .DATA_W (W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who owns the port, where the search resumes, and the output register.
  int         m_owner;
  int         m_ptr;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_ol;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        rdy;
    logic [31:0] dat;
    logic [3:0]  e_gnt;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_last;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] last, input logic rdy,
                       input logic [31:0] dat);
    bus.iVld  = vld;
    bus.iLast = last;
    bus.iRdy  = rdy;
    bus.iDat  = dat;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_oVld"}, 32'(bus.oVld), 32'd0);
    chk({name, "_oDat"}, 32'(bus.oDat), 32'd0);
    chk({name, "_oLast"}, 32'(bus.oLast), 32'd0);
    chk({name, "_oGnt"}, 32'(bus.oGnt), 32'd0);
    chk({name, "_oRdy"}, 32'(bus.oRdy), 32'd0);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_ov    = 1'b0;
    m_od    = '0;
    m_ol    = 1'b0;
  endtask

  task automatic do_reset();
    drive(4'b0, 4'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [3:0] exp_rdy();
    if (m_owner < 0) return 4'b0;
    if (m_ov && !bus.iRdy) return 4'b0;
    return 4'(1 << m_owner);
  endfunction

  function automatic logic [3:0] exp_gnt();
    if (m_owner < 0) return 4'b0;
    return 4'(1 << m_owner);
  endfunction

  task automatic model_step();
    logic [3:0] r;
    int         idx;
    r = exp_rdy();
    if (m_ov && bus.iRdy) m_ov = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && bus.iVld[idx]) m_owner = idx;
      end
    end else if (bus.iVld[m_owner] && r[m_owner]) begin
      m_ov = 1'b1;
      m_od = bus.iDat[m_owner*W +: W];
      m_ol = PktLock ? bus.iLast[m_owner] : 1'b1;
      if (!PktLock || bus.iLast[m_owner]) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic        rr;
    logic [31:0] rd;

    // Alternating grants between requesters 0 and 2, one beat per packet.
    tbl[0] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0001};
    tbl[1] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0000, 1'b1, 8'h10, 1'b1, 4'b0000};
    tbl[2] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0100, 1'b0, 8'h10, 1'b1, 4'b0100};
    tbl[3] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0000, 1'b1, 8'h12, 1'b1, 4'b0000};
    tbl[4] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0001, 1'b0, 8'h12, 1'b1, 4'b0001};
    tbl[5] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0000, 1'b1, 8'h10, 1'b1, 4'b0000};
    tbl[6] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0100, 1'b0, 8'h10, 1'b1, 4'b0100};
    tbl[7] = '{4'b0101, 4'b1111, 1'b1, 32'h13121110, 4'b0000, 1'b1, 8'h12, 1'b1, 4'b0000};

    drive(4'b0, 4'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].vld, tbl[i].last, tbl[i].rdy, tbl[i].dat);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_oGnt", i), 32'(bus.oGnt), 32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_oVld", i), 32'(bus.oVld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_oDat", i), 32'(bus.oDat), 32'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_oLast", i), 32'(bus.oLast), 32'(tbl[i].e_last));
      chk($sformatf("tbl%0d_oRdy", i), 32'(bus.oRdy), 32'(tbl[i].e_rdy));
    end

    // Downstream stall: A5 must hold, nothing accepted, then A6 follows exactly once.
    do_reset();
    drive(4'b0001, 4'b1111, 1'b0, 32'h000000A5);
    @(posedge clk); #1;
    chk("stall_gnt", 32'(bus.oGnt), 32'h1);
    chk("stall_rdy0", 32'(bus.oRdy), 32'h1);
    @(posedge clk); #1;
    chk("stall_vld0", 32'(bus.oVld), 32'h1);
    chk("stall_dat0", 32'(bus.oDat), 32'hA5);
    bus.iDat = 32'h000000A6;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_vld", i), 32'(bus.oVld), 32'h1);
      chk($sformatf("stall%0d_dat", i), 32'(bus.oDat), 32'hA5);
      chk($sformatf("stall%0d_rdy", i), 32'(bus.oRdy), 32'h0);
      chk($sformatf("stall%0d_gnt", i), 32'(bus.oGnt), 32'h1);
    end
    bus.iRdy = 1'b1;
    #1;
    chk("stall_release_rdy", 32'(bus.oRdy), 32'h1);
    @(posedge clk); #1;
    chk("stall_next_vld", 32'(bus.oVld), 32'h1);
    chk("stall_next_dat", 32'(bus.oDat), 32'hA6);
    bus.iVld = 4'b0;
    @(posedge clk); #1;
    chk("stall_drained", 32'(bus.oVld), 32'h0);

    // Pointer wrap from 3 to 0, then on to 3.
    do_reset();
    drive(4'b1001, 4'b1111, 1'b1, 32'h33000000);
    @(posedge clk); #1;
    chk("wrap_gnt0", 32'(bus.oGnt), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_gnt3", 32'(bus.oGnt), 32'h8);

    // Asynchronous reset with a beat parked in the output register.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0, 32'h0000D100);
    @(posedge clk); #1;
    chk("rstmid_gnt", 32'(bus.oGnt), 32'h2);
    @(posedge clk); #1;
    chk("rstmid_dat1", 32'(bus.oDat), 32'hD1);
    bus.iDat = 32'h0000D200;
    @(posedge clk); #1;
    chk("rstmid_vld", 32'(bus.oVld), 32'h1);
    chk("rstmid_gnt2", 32'(bus.oGnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(4'b1111, 4'b1111, 1'b1, 32'h0);
    @(posedge clk); #1;
    chk("rstmid_first_gnt", 32'(bus.oGnt), 32'h1);

`ifdef ZION_ARB_RR_PKT_LOCK_EN
    // Three-beat packet from requester 1 keeps the grant while requester 0 waits.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b1, 32'h0000B100);
    @(posedge clk); #1;
    chk("pkt_gnt_b0", 32'(bus.oGnt), 32'h2);
    @(posedge clk); #1;
    chk("pkt_gnt_b1", 32'(bus.oGnt), 32'h2);
    chk("pkt_dat_b1", 32'(bus.oDat), 32'hB1);
    drive(4'b0011, 4'b0000, 1'b1, 32'h0000B200);
    @(posedge clk); #1;
    chk("pkt_gnt_b2", 32'(bus.oGnt), 32'h2);
    chk("pkt_dat_b2", 32'(bus.oDat), 32'hB2);
    chk("pkt_last_b2", 32'(bus.oLast), 32'h0);
    drive(4'b0011, 4'b0010, 1'b1, 32'h0000B300);
    @(posedge clk); #1;
    chk("pkt_bubble", 32'(bus.oGnt), 32'h0);
    chk("pkt_dat_b3", 32'(bus.oDat), 32'hB3);
    chk("pkt_last_b3", 32'(bus.oLast), 32'h1);
    @(posedge clk); #1;
    chk("pkt_next_gnt", 32'(bus.oGnt), 32'h1);
`else
    // Per-beat arbitration ignores iLast and marks every beat as last.
    do_reset();
    drive(4'b0011, 4'b0000, 1'b1, 32'h0000C2C1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("beat%0d_gnt", i), 32'(bus.oGnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      @(posedge clk); #1;
      chk($sformatf("beat%0d_vld", i), 32'(bus.oVld), 32'h1);
      chk($sformatf("beat%0d_last", i), 32'(bus.oLast), 32'h1);
      chk($sformatf("beat%0d_dat", i), 32'(bus.oDat), (i % 2 == 0) ? 32'hC1 : 32'hC2);
    end
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rv = 4'($urandom);
      if ($urandom_range(3) == 0) rv = 4'b0;
      rl = 4'($urandom);
      rr = ($urandom_range(3) != 0);
      rd = $urandom;
      drive(rv, rl, rr, rd);
      #1;
      chk("rnd_oRdy", 32'(bus.oRdy), 32'(exp_rdy()));
      model_step();
      @(posedge clk); #1;
      chk("rnd_oGnt", 32'(bus.oGnt), 32'(exp_gnt()));
      chk("rnd_oVld", 32'(bus.oVld), 32'(m_ov));
      chk("rnd_oDat", 32'(bus.oDat), 32'(m_od));
      chk("rnd_oLast", 32'(bus.oLast), 32'(m_ol));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/zion_arb_rr_lock.md
ZION_ARB_RR_LOCK -- requirements
Module: zion_arb_rr_lock

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..32; an elaboration-time error is raised outside this range).
REQ-002 SHALL have parameter DATA_W, default 8, data width per requester.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port iVld  input  NUM_REQ  per-requester valid.
REQ-006 SHALL have port oRdy  output  NUM_REQ  per-requester ready.
REQ-007 SHALL have port iDat  input  NUM_REQ*DATA_W  packed requester data, requester i at [i*DATA_W +: DATA_W].
REQ-008 SHALL have port iLast  input  NUM_REQ  per-requester end-of-packet flag.
REQ-009 SHALL have port oVld  output  1  shared-port valid.
REQ-010 SHALL have port iRdy  input  1  shared-port ready from downstream.
REQ-011 SHALL have port oDat  output  DATA_W  shared-port data.
REQ-012 SHALL have port oLast  output  1  shared-port end-of-packet.
REQ-013 SHALL have port oGnt  output  NUM_REQ  one-hot current grant; all zero when idle.

Function
REQ-014 SHALL implement FSM states IDLE and LOCK.
REQ-015 IDLE: if any iVld, SHALL select by round-robin, lowest index first, starting at (ptr+1) mod NUM_REQ; load oGnt; enter LOCK next cycle; oRdy all zero in IDLE.
REQ-016 LOCK: oRdy[g] = ~oVld | iRdy for granted g only; all other oRdy bits zero.
REQ-017 Beat accepted when iVld[g] & oRdy[g]; oDat/oLast/oVld SHALL be registered, visible the cycle after acceptance (latency 1).
REQ-018 oVld SHALL clear on iRdy & oVld when no new beat is accepted in the same cycle; oDat/oLast SHALL stay stable while oVld & ~iRdy.
REQ-019 Accepted beat with iLast[g]=1: next state IDLE, ptr <= g, oGnt cleared; one bubble cycle between packets.
REQ-020 iVld[g] dropping mid-packet SHALL NOT release the grant; LOCK is held until the last beat is accepted.
REQ-021 Pointer wrap: ptr=NUM_REQ-1 SHALL search from index 0.
REQ-022 Requests arriving in the same cycle SHALL be resolved solely by REQ-015; a request arriving while in LOCK waits for IDLE.

Reset
REQ-023 On rst_n low: state IDLE, ptr = NUM_REQ-1, oVld=0, oDat=0, oLast=0, oGnt=0, oRdy=0, immediately and independently of clk.
REQ-024 Reset mid-packet SHALL discard the packet in flight with no partial-output retention.

Configuration
REQ-025 Macro ZION_ARB_RR_PKT_LOCK_EN defined: packet locking per REQ-019/020.
REQ-026 Macro undefined: iLast ignored; every accepted beat behaves as last; oLast driven 1 whenever oVld; arbitration per beat.

Structure
REQ-027 Package zion_arb_pkg SHALL hold the state enum typedef (IDLE, LOCK) and function rr_pick(req, ptr) returning a one-hot grant.
REQ-028 SHALL instantiate one sub-module zion_arb_rr_pick: combinational rotated-priority one-hot picker (req, ptr -> gnt) wrapping rr_pick.

Verification
REQ-029 Reset, then iVld=4'b0101 held, each beat iLast=1, iRdy=1 -> grants alternate 0,2,0,2; oDat matches the granted source.
REQ-030 PKT_LOCK_EN defined; req1 sends 3 beats (iLast on beat 3); req0 asserts mid-packet -> oGnt stays 4'b0010 until beat 3 is accepted, then 4'b0001 after a one-cycle bubble.
REQ-031 iRdy=0 for 5 cycles with oVld=1, oDat=8'hA5 -> oDat holds 8'hA5; oRdy[g]=0; no beat lost or duplicated.
REQ-032 ptr=3, iVld=4'b1001 -> grant 4'b0001 (wrap); next grant 4'b1000.
REQ-033 rst_n low during the 2nd beat of a packet -> all outputs zero in the same cycle; after release, first grant is index 0 when iVld=4'b1111.
REQ-034 Macro undefined; iVld=4'b0011, iLast=0 -> per-beat grants 0,1,0,1; oLast=1 on every oVld.
